// File: rtl/mc_controlunit.sv
// ---------------------------------------------------------------------------
// mc_controlunit
// Multicycle control unit for the cpu55 MIPS subset. It steps each
// instruction through IF, ID, EX, MEM and WB, and drives the datapath
// control set for each state. It handles variable-latency memory
// handshakes with an optional timeout, traps undecoded instructions, and
// counts retired instructions.
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   op, func, rs, rt, rd latched IR fields
//   zero, negtive        ALU flags, valid in EX
//   mem_ack              memory completes the request this cycle
//   mem_req, mem_we      memory request / store qualifier
//   ir_we, pc_we         IR latch and PC update strobes
//   pcsource             00 pc+4, 01 branch, 10 jr, 11 jump
//   aluc, immc, sext_i,
//   shift, regwa         ALU and operand-select controls
//   w, h, b, z           access width and zero-extend for loads
//   wrf, wdc             register-file write and writeback source
//   busy, illegal,
//   timeout, retired     status
// ---------------------------------------------------------------------------
module mc_controlunit #(
    parameter int unsigned RW     = 5,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned MEM_TO = 255
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic [RW-1:0]    rs,
    input  logic [RW-1:0]    rt,
    input  logic [RW-1:0]    rd,
    input  logic             zero,
    input  logic             negtive,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pcsource,
    output logic [3:0]       aluc,
    output logic             w,
    output logic             h,
    output logic             b,
    output logic             z,
    output logic             wrf,
    output logic             regwa,
    output logic             immc,
    output logic             sext_i,
    output logic             shift,
    output logic             wdc,
    output logic             busy,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {StIf, StId, StEx, StMem, StWb, StHalt} t_state;
    typedef enum logic [2:0] {ClsAlu, ClsJr, ClsBr, ClsJmp, ClsLoad, ClsStore} t_cls;

    localparam int unsigned WW = (MEM_TO > 1) ? $clog2(MEM_TO) : 1;
    localparam logic [WW-1:0] WAIT_LAST = (MEM_TO > 0) ? WW'(MEM_TO - 1) : '0;

    // rs/rd only steer the datapath; the controller never looks at them.
    logic w_unused;
    assign w_unused = ^{rs, rd};

    t_state          r_state, w_state_d;
    logic            r_armed;
    logic [WW-1:0]   r_wait, w_wait_d;
    logic            r_timeout, w_to_set;
    logic [CNT_W-1:0] r_retired;
    logic            w_retire;

    // Decoded fields, captured at the end of ID.
    t_cls            r_cls;
    logic [3:0]      r_aluc;
    logic            r_immc, r_sext, r_shift, r_regwa;
    logic [1:0]      r_brk;           // 0 beq, 1 bne, 2 bltz, 3 bgez
    logic [3:0]      r_size;          // {w, h, b, z}

    // Combinational decode of the live IR fields.
    logic            w_legal;
    t_cls            w_cls;
    logic [3:0]      w_aluc;
    logic            w_immc, w_sext, w_shift, w_regwa;
    logic [1:0]      w_brk;
    logic [3:0]      w_size;

    always_comb begin
        w_legal = 1'b1;
        w_cls   = ClsAlu;
        w_aluc  = 4'h0;
        w_immc  = 1'b0;
        w_sext  = 1'b0;
        w_shift = 1'b0;
        w_regwa = 1'b0;
        w_brk   = 2'd0;
        w_size  = 4'b0000;
        case (op)
            6'h00: begin
                case (func)
                    6'h20, 6'h21: w_aluc = 4'h0;
                    6'h22, 6'h23: w_aluc = 4'h1;
                    6'h24:        w_aluc = 4'h2;
                    6'h25:        w_aluc = 4'h3;
                    6'h26:        w_aluc = 4'h4;
                    6'h27:        w_aluc = 4'h5;
                    6'h2A:        w_aluc = 4'h6;
                    6'h2B:        w_aluc = 4'h7;
                    6'h00: begin w_aluc = 4'h8; w_shift = 1'b1; end
                    6'h02: begin w_aluc = 4'h9; w_shift = 1'b1; end
                    6'h03: begin w_aluc = 4'hA; w_shift = 1'b1; end
                    6'h08:        w_cls   = ClsJr;
                    default:      w_legal = 1'b0;
                endcase
            end
            6'h01: begin
                w_cls  = ClsBr;
                w_aluc = 4'h1;
                if (rt == '0) begin
                    w_brk = 2'd2;
                end else if (rt == RW'(1)) begin
                    w_brk = 2'd3;
                end else begin
                    w_legal = 1'b0;
                end
            end
            6'h02, 6'h03: w_cls = ClsJmp;
            6'h04: begin w_cls = ClsBr; w_aluc = 4'h1; w_brk = 2'd0; end
            6'h05: begin w_cls = ClsBr; w_aluc = 4'h1; w_brk = 2'd1; end
            6'h08, 6'h09: begin w_aluc = 4'h0; w_immc = 1'b1; w_regwa = 1'b1; w_sext = 1'b1; end
            6'h0A: begin w_aluc = 4'h6; w_immc = 1'b1; w_regwa = 1'b1; w_sext = 1'b1; end
            6'h0C: begin w_aluc = 4'h2; w_immc = 1'b1; w_regwa = 1'b1; end
            6'h0D: begin w_aluc = 4'h3; w_immc = 1'b1; w_regwa = 1'b1; end
            6'h0E: begin w_aluc = 4'h4; w_immc = 1'b1; w_regwa = 1'b1; end
            6'h0F: begin w_aluc = 4'hB; w_immc = 1'b1; w_regwa = 1'b1; w_sext = 1'b1; end
            6'h23, 6'h21, 6'h25, 6'h20, 6'h24: begin
                w_cls   = ClsLoad;
                w_immc  = 1'b1;
                w_sext  = 1'b1;
                w_regwa = 1'b1;
                case (op)
                    6'h23:   w_size = 4'b1000;
                    6'h21:   w_size = 4'b0100;
                    6'h25:   w_size = 4'b0101;
                    6'h20:   w_size = 4'b0010;
                    default: w_size = 4'b0011;
                endcase
            end
            6'h2B, 6'h29, 6'h28: begin
                w_cls  = ClsStore;
                w_immc = 1'b1;
                w_sext = 1'b1;
                case (op)
                    6'h2B:   w_size = 4'b1000;
                    6'h29:   w_size = 4'b0100;
                    default: w_size = 4'b0010;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cls   <= ClsAlu;
            r_aluc  <= 4'h0;
            r_immc  <= 1'b0;
            r_sext  <= 1'b0;
            r_shift <= 1'b0;
            r_regwa <= 1'b0;
            r_brk   <= 2'd0;
            r_size  <= 4'b0000;
        end else if (r_state == StId && w_legal) begin
            r_cls   <= w_cls;
            r_aluc  <= w_aluc;
            r_immc  <= w_immc;
            r_sext  <= w_sext;
            r_shift <= w_shift;
            r_regwa <= w_regwa;
            r_brk   <= w_brk;
            r_size  <= w_size;
        end
    end

    logic w_taken;
    always_comb begin
        w_taken = 1'b0;
        unique case (r_brk)
            2'd0: w_taken = zero;
            2'd1: w_taken = !zero;
            2'd2: w_taken = negtive;
            2'd3: w_taken = !negtive;
        endcase
    end

    logic w_to_hit;
    assign w_to_hit = (MEM_TO != 0) && (r_wait == WAIT_LAST);

    // Next state and per-state outputs.
    always_comb begin
        w_state_d = r_state;
        w_wait_d  = r_wait;
        w_to_set  = 1'b0;
        w_retire  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pcsource  = 2'b00;
        aluc      = 4'h0;
        {w, h, b, z} = 4'b0000;
        wrf       = 1'b0;
        regwa     = 1'b0;
        immc      = 1'b0;
        sext_i    = 1'b0;
        shift     = 1'b0;
        wdc       = 1'b0;
        illegal   = 1'b0;

        // Hold ALU/operand controls stable from EX through WB.
        if (r_state == StEx || r_state == StMem || r_state == StWb) begin
            aluc   = r_aluc;
            immc   = r_immc;
            sext_i = r_sext;
            shift  = r_shift;
            regwa  = r_regwa;
        end

        case (r_state)
            StIf: begin
                // The first cycle after reset is an idle IF with no request.
                if (r_armed) begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        ir_we     = 1'b1;
                        pc_we     = 1'b1;
                        w_state_d = StId;
                    end else if (w_to_hit) begin
                        w_to_set  = 1'b1;
                        w_state_d = StHalt;
                    end else begin
                        w_wait_d = r_wait + 1'b1;
                    end
                end
            end
            StId: begin
                if (w_legal) begin
                    w_state_d = StEx;
                end else begin
                    illegal   = 1'b1;
                    w_state_d = StIf;
                end
            end
            StEx: begin
                case (r_cls)
                    ClsJr: begin
                        pc_we     = 1'b1;
                        pcsource  = 2'b10;
                        w_retire  = 1'b1;
                        w_state_d = StIf;
                    end
                    ClsBr: begin
                        pc_we     = w_taken;
                        pcsource  = w_taken ? 2'b01 : 2'b00;
                        w_retire  = 1'b1;
                        w_state_d = StIf;
                    end
                    ClsJmp: begin
                        pc_we     = 1'b1;
                        pcsource  = 2'b11;
                        w_retire  = 1'b1;
                        w_state_d = StIf;
                    end
                    ClsLoad, ClsStore: w_state_d = StMem;
                    default:           w_state_d = StWb;
                endcase
            end
            StMem: begin
                mem_req      = 1'b1;
                mem_we       = (r_cls == ClsStore);
                {w, h, b, z} = r_size;
                if (mem_ack) begin
                    if (r_cls == ClsStore) begin
                        w_retire  = 1'b1;
                        w_state_d = StIf;
                    end else begin
                        w_state_d = StWb;
                    end
                end else if (w_to_hit) begin
                    w_to_set  = 1'b1;
                    w_state_d = StHalt;
                end else begin
                    w_wait_d = r_wait + 1'b1;
                end
            end
            StWb: begin
                wrf = 1'b1;
                if (r_cls == ClsLoad) begin
                    wdc          = 1'b1;
                    {w, h, b, z} = r_size;
                end
                w_retire  = 1'b1;
                w_state_d = StIf;
            end
            StHalt: begin
                aluc   = 4'h0;
                immc   = 1'b0;
                sext_i = 1'b0;
                shift  = 1'b0;
                regwa  = 1'b0;
            end
            default: w_state_d = StIf;
        endcase

        // Each new request window starts a fresh wait count.
        if (w_state_d != r_state && (w_state_d == StIf || w_state_d == StMem)) begin
            w_wait_d = '0;
        end
    end

    assign busy    = !(r_state == StIf && !r_armed);
    assign timeout = r_timeout;
    assign retired = r_retired;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= StIf;
            r_armed   <= 1'b0;
            r_wait    <= '0;
            r_timeout <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_state_d;
            r_armed <= 1'b1;
            r_wait  <= w_wait_d;
            if (w_to_set) begin
                r_timeout <= 1'b1;
            end
            if (w_retire) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

endmodule
